homeostat_bank: RTL and testbench

//  Parametrised bank of CH independent drive counters (energy, stress, pleasure, nourishment, ...).

---
 rtl/homeostat_bank_if.sv | 40 ++++
 rtl/homeostat_bank.sv | 134 +++++++++++++
 tb/tb_homeostat_bank.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/homeostat_bank_if.sv
// -----------------------------------------------------------------------------
// homeostat_bank_if
//   Bundles the control inputs and the status outputs of homeostat_bank.
//   There is no valid/ready handshake: 'tick' is a plain enable. Requests
//   (inc/dec/load/step/load_val/leak_en) are sampled on a clk edge where
//   tick=1. Outputs are always valid and reflect the registered counters.
//
//   master : drives tick, inc, dec, step, load, load_val, leak_en;
//            observes value, level, at_min, at_max, critical, any_critical
//   slave  : the bank itself (mirror directions)
// -----------------------------------------------------------------------------
interface homeostat_bank_if #(
  parameter int CH     = 4,
  parameter int W      = 7,
  parameter int STEP_W = 3
);
  logic                tick;
  logic [CH-1:0]       inc;
  logic [CH-1:0]       dec;
  logic [CH*STEP_W-1:0] step;
  logic [CH-1:0]       load;
  logic [CH*W-1:0]     load_val;
  logic                leak_en;
  logic [CH*W-1:0]     value;
  logic [CH*2-1:0]     level;
  logic [CH-1:0]       at_min;
  logic [CH-1:0]       at_max;
  logic [CH-1:0]       critical;
  logic                any_critical;

  modport master (
    output tick, inc, dec, step, load, load_val, leak_en,
    input  value, level, at_min, at_max, critical, any_critical
  );

  modport slave (
    input  tick, inc, dec, step, load, load_val, leak_en,
    output value, level, at_min, at_max, critical, any_critical
  );
endinterface

// File: rtl/homeostat_bank.sv
// -----------------------------------------------------------------------------
// homeostat_bank
//   Bank of CH independent saturating drive counters. Each channel supports
//   load, variable-step increment/decrement with clamping, a slow leak toward
//   REST_VAL while idle, a 2-bit quartile level and a sticky critical flag
//   that sets after the value has sat at 0 for CRIT_TICKS consecutive ticks.
//   All state advances only on clk edges with tick=1.
//
//   clk, rst : clock, asynchronous active-high reset
//   bus      : homeostat_bank_if.slave (requests in, counter status out)
// -----------------------------------------------------------------------------
module homeostat_bank #(
  parameter int CH         = 4,
  parameter int W          = 7,
  parameter int STEP_W     = 3,
  parameter int RESET_VAL  = 96,
  parameter int REST_VAL   = 64,
  parameter int LEAK_DIV   = 4,
  parameter int CRIT_TICKS = 3
) (
  input logic            clk,
  input logic            rst,
  homeostat_bank_if.slave bus
);

  localparam int LEAK_W = $clog2(LEAK_DIV);
  localparam int ZR_W   = $clog2(CRIT_TICKS + 1);

  localparam logic [W-1:0]      MAX_V    = {W{1'b1}};
  localparam logic [W-1:0]      RST_V    = W'(RESET_VAL);
  localparam logic [W-1:0]      REST_V   = W'(REST_VAL);
  localparam logic [LEAK_W-1:0] LEAK_TOP = LEAK_W'(LEAK_DIV - 1);
  localparam logic [ZR_W-1:0]   ZR_TOP   = ZR_W'(CRIT_TICKS);

  logic [W-1:0]      value_q [CH];
  logic [W-1:0]      value_d [CH];
  logic [LEAK_W-1:0] leak_q  [CH];
  logic [LEAK_W-1:0] leak_d  [CH];
  logic [ZR_W-1:0]   zr_q    [CH];
  logic [ZR_W-1:0]   zr_d    [CH];
  logic [CH-1:0]     crit_q;
  logic [CH-1:0]     crit_d;

  // Scratch values reused per channel inside the loop below.
  logic [STEP_W-1:0] stp;
  logic [W:0]        stp_ext;
  logic [W:0]        sum;

  always_comb begin
    stp     = '0;
    stp_ext = '0;
    sum     = '0;
    crit_d  = crit_q;
    for (int c = 0; c < CH; c++) begin
      value_d[c] = value_q[c];
      leak_d[c]  = leak_q[c];
      zr_d[c]    = zr_q[c];

      // A step of zero still moves the counter by one.
      stp     = bus.step[c*STEP_W +: STEP_W];
      if (stp == '0) stp = STEP_W'(1);
      stp_ext = (W+1)'(stp);
      sum     = {1'b0, value_q[c]} + stp_ext;

      if (bus.tick) begin
        if (bus.load[c]) begin
          value_d[c] = bus.load_val[c*W +: W];
          crit_d[c]  = 1'b0;
          leak_d[c]  = '0;
          zr_d[c]    = '0;
        end else begin
          if (bus.inc[c] && bus.dec[c]) begin
            leak_d[c] = '0;
          end else if (bus.inc[c]) begin
            value_d[c] = sum[W] ? MAX_V : sum[W-1:0];
            leak_d[c]  = '0;
          end else if (bus.dec[c]) begin
            // Compare in W+1 bits so a large step clamps at 0 instead of wrapping.
            if ({1'b0, value_q[c]} <= stp_ext) value_d[c] = '0;
            else value_d[c] = value_q[c] - stp_ext[W-1:0];
            leak_d[c] = '0;
          end else if (leak_q[c] == LEAK_TOP) begin
            // Interval elapsed: leak if enabled, otherwise park here so the
            // first idle tick after enabling leaks immediately.
            if (bus.leak_en) begin
              if (value_q[c] > REST_V)      value_d[c] = value_q[c] - W'(1);
              else if (value_q[c] < REST_V) value_d[c] = value_q[c] + W'(1);
              leak_d[c] = '0;
            end
          end else begin
            leak_d[c] = leak_q[c] + LEAK_W'(1);
          end

          // Zero-run tracking looks at the post-update value.
          if (value_d[c] == '0) begin
            if (zr_q[c] != ZR_TOP) zr_d[c] = zr_q[c] + ZR_W'(1);
            if (zr_d[c] == ZR_TOP) crit_d[c] = 1'b1;
          end else begin
            zr_d[c] = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        value_q[c] <= RST_V;
        leak_q[c]  <= '0;
        zr_q[c]    <= '0;
      end
      crit_q <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        value_q[c] <= value_d[c];
        leak_q[c]  <= leak_d[c];
        zr_q[c]    <= zr_d[c];
      end
      crit_q <= crit_d;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_out
    assign bus.value[g*W +: W] = value_q[g];
    assign bus.level[g*2 +: 2] = value_q[g][W-1:W-2];
    assign bus.at_min[g]       = (value_q[g] == '0);
    assign bus.at_max[g]       = (value_q[g] == MAX_V);
  end

  assign bus.critical     = crit_q;
  assign bus.any_critical = |crit_q;

endmodule

// File: tb/tb_homeostat_bank.sv
module tb_homeostat_bank;
  localparam int CH     = 4;
  localparam int W      = 7;
  localparam int STEP_W = 3;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  homeostat_bank_if #(.CH(CH), .W(W), .STEP_W(STEP_W)) bus ();

  homeostat_bank #(
    .CH(CH), .W(W), .STEP_W(STEP_W), .RESET_VAL(96), .REST_VAL(64),
    .LEAK_DIV(4), .CRIT_TICKS(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int get_val(input int c);
    return int'(bus.value[c*W +: W]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_req();
    bus.inc      = '0;
    bus.dec      = '0;
    bus.load     = '0;
    bus.step     = '0;
    bus.load_val = '0;
  endtask

  task automatic set_step(input int c, input int s);
    bus.step[c*STEP_W +: STEP_W] = STEP_W'(s);
  endtask

  task automatic set_load(input int c, input int v);
    bus.load[c]              = 1'b1;
    bus.load_val[c*W +: W]   = W'(v);
  endtask

  // One tick edge; outputs sampled 1 time unit after it, requests cleared.
  task automatic do_tick();
    bus.tick = 1'b1;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    clear_req();
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks     = 0;
    n_errors     = 0;
    bus.tick     = 1'b0;
    bus.leak_en  = 1'b0;
    clear_req();
    rst = 1'b1;
    #2;
    for (int c = 0; c < CH; c++) begin
      check($sformatf("reset_val%0d", c), get_val(c), 96);
      check($sformatf("reset_lvl%0d", c), int'(bus.level[c*2 +: 2]), 3);
    end
    check("reset_crit", int'(bus.critical), 0);
    check("reset_any", int'(bus.any_critical), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Saturation on ch0
    set_load(0, 125);
    do_tick();
    check("sat_load", get_val(0), 125);
    bus.inc[0] = 1'b1; set_step(0, 5);
    do_tick();
    check("sat_inc", get_val(0), 127);
    check("sat_atmax", int'(bus.at_max[0]), 1);
    check("sat_lvl", int'(bus.level[1:0]), 3);
    bus.dec[0] = 1'b1; set_step(0, 0);
    do_tick();
    check("step0_dec", get_val(0), 126);
    check("step0_atmax", int'(bus.at_max[0]), 0);

    // Cancel / priority on ch1
    bus.inc[1] = 1'b1; bus.dec[1] = 1'b1; set_step(1, 3);
    do_tick();
    check("cancel", get_val(1), 96);
    bus.inc[1] = 1'b1; set_step(1, 3); set_load(1, 10);
    do_tick();
    check("load_prio", get_val(1), 10);
    bus.inc[1] = 1'b1; set_step(1, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("no_tick", get_val(1), 10);
    clear_req();

    // Leak on ch2 (load clears its leak counter first)
    set_load(2, 96);
    do_tick();
    bus.leak_en = 1'b1;
    idle_ticks(3);
    check("leak_3", get_val(2), 96);
    idle_ticks(1);
    check("leak_4", get_val(2), 95);
    idle_ticks(4);
    check("leak_8", get_val(2), 94);
    idle_ticks(2);
    bus.inc[2] = 1'b1; set_step(2, 1);
    do_tick();
    check("leak_inc", get_val(2), 95);
    idle_ticks(3);
    check("leak_restart3", get_val(2), 95);
    idle_ticks(1);
    check("leak_restart4", get_val(2), 94);
    set_load(2, 64);
    do_tick();
    idle_ticks(8);
    check("leak_rest", get_val(2), 64);
    check("lvl_64", int'(bus.level[5:4]), 2);

    // Leak disabled then re-enabled
    set_load(2, 80);
    do_tick();
    bus.leak_en = 1'b0;
    idle_ticks(10);
    check("noleak_10", get_val(2), 80);
    bus.leak_en = 1'b1;
    idle_ticks(1);
    check("leak_resume", get_val(2), 79);
    bus.leak_en = 1'b0;

    // Critical on ch3
    set_load(3, 5);
    do_tick();
    bus.dec[3] = 1'b1; set_step(3, 7);
    do_tick();
    check("crit_dec0", get_val(3), 0);
    check("crit_atmin", int'(bus.at_min[3]), 1);
    check("crit_z1", int'(bus.critical[3]), 0);
    bus.dec[3] = 1'b1; set_step(3, 7);
    do_tick();
    check("crit_z2", int'(bus.critical[3]), 0);
    bus.dec[3] = 1'b1; set_step(3, 7);
    do_tick();
    check("crit_z3", int'(bus.critical[3]), 1);
    check("crit_any", int'(bus.any_critical), 1);
    bus.inc[3] = 1'b1; set_step(3, 7);
    do_tick();
    bus.inc[3] = 1'b1; set_step(3, 1);
    do_tick();
    check("crit_inc8", get_val(3), 8);
    check("crit_sticky", int'(bus.critical[3]), 1);
    set_load(3, 30);
    do_tick();
    check("crit_clr", int'(bus.critical[3]), 0);
    check("crit_any_clr", int'(bus.any_critical), 0);

    // Simultaneous events on all channels
    set_load(0, 20); set_load(1, 30); set_load(2, 40); set_load(3, 50);
    do_tick();
    bus.inc[0] = 1'b1; set_step(0, 2);
    bus.dec[1] = 1'b1; set_step(1, 3);
    set_load(2, 5);
    bus.inc[3] = 1'b1; bus.dec[3] = 1'b1; set_step(3, 4);
    do_tick();
    check("multi0", get_val(0), 22);
    check("multi1", get_val(1), 27);
    check("multi2", get_val(2), 5);
    check("multi3", get_val(3), 50);
    bus.dec[2] = 1'b1; set_step(2, 7);
    do_tick();
    check("dec_clamp", get_val(2), 0);

    // Async reset mid-cycle with a critical flag set
    set_load(3, 0);
    do_tick();
    for (int i = 0; i < 3; i++) begin
      bus.dec[3] = 1'b1;
      do_tick();
    end
    check("pre_rst_crit", int'(bus.critical[3]), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_v0", get_val(0), 96);
    check("mid_rst_v3", get_val(3), 96);
    check("mid_rst_crit", int'(bus.critical), 0);
    check("mid_rst_any", int'(bus.any_critical), 0);
    #3;
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
